pool_window_scheduler: RTL and testbench
========================================

// Module: pool_window_scheduler
// PURPOSE
// Frame sequencer for the average-pooling datapath. Accepts one image frame per start over a
// valid/ready pixel stream and drives the datapath's pixel/isValid inputs. Tracks row/column
// position, flags every pixel that completes a pooling window, and collects averages into a
// result FIFO. Throttles input so results are never lost, then flushes the datapath at frame end.
// PARAMETERS
// bitwidth     8   pixel and average width
// filterWidth  3   pooling window edge (window is filterWidth x filterWidth)
// imageWidth   11  pixels per row
// imageHeight  11  rows per frame
// stride       3   window step, horizontal and vertical
// fifoDepth    4   result FIFO entries, power of 2, >=2
// flushLimit   64  max zero-pixel flush cycles in DRAIN before error
// PORTS
// clock          in   1         rising-edge clock
// reset          in   1         asynchronous, active-high
// start          in   1         begin frame; sampled in IDLE only
// busy           out  1         high in STREAM and DRAIN
// done           out  1         one-cycle pulse when the frame completes
// error          out  1         sticky until reset or next accepted start: overflow or flush timeout
// pix_data       in   bitwidth  input pixel, row-major
// pix_valid      in   1         pix_data valid
// pix_ready      out  1         scheduler accepts pixel this cycle
// dp_data        out  bitwidth  pixel to datapath data_in
// dp_valid       out  1         datapath isValid
// dp_window_end  out  1         with dp_valid: this pixel completes a window
// dp_avg         in   bitwidth  datapath average_out
// dp_avg_ready   in   1         one-cycle pulse per finished average
// res_data       out  bitwidth  pooled result
// res_index      out  16        window number, row-major, 0-based
// res_valid      out  1         FIFO head valid
// res_ready      in   1         consumer takes head
// BEHAVIOUR
// - Reset (async): IDLE; all outputs 0; counters, FIFO and credits cleared; error cleared.
// - nWin = ((imageWidth-filterWidth)/stride+1) * ((imageHeight-filterWidth)/stride+1); 9 at defaults.
// - FSM IDLE -> STREAM on start; start ignored outside IDLE. Accepted start clears error and counters.
// - STREAM -> DRAIN when pixel imageWidth*imageHeight-1 is accepted.
// - DRAIN -> DONE when all nWin results are received; DONE -> IDLE after 1 cycle, done=1 in DONE.
// - Accept = pix_valid & pix_ready. pix_ready = STREAM & (outstanding+fifoCount < fifoDepth).
// - Latency 1: cycle after accept, dp_valid=1 and dp_data=pixel; otherwise dp_valid=0 and dp_data holds.
// - col wraps imageWidth-1 -> 0 and increments row. window_end = col>=filterWidth-1 and
//   (col-filterWidth+1)%stride==0, with the same test on row. Registered with dp_data.
// - outstanding increments on each window_end issue and decrements on dp_avg_ready.
//   Simultaneous events leave it unchanged.
// - dp_avg_ready pushes {dp_avg,resIdx} into FIFO; resIdx increments per push. Push when full or when
//   outstanding==0: drop result, set error.
// - Pop on res_valid & res_ready. Push and pop in the same cycle are legal when full.
//   res_valid=0 when FIFO is empty.
// - DRAIN: each cycle with outstanding>0, drive dp_valid=1, dp_data=0, dp_window_end=0 to flush the
//   pipeline. After flushLimit flush cycles, set error and go to DONE.
// - FIFO contents persist through DONE/IDLE until popped. A new frame may start while it is non-empty.
// - Results received never exceed nWin per frame; extra pulses are treated as overflow.
// TESTING
// - Defaults, 121 pixels 0..120 streamed, res_ready=1 with reference avg model -> 9 results,
//   index 0..8; first avg equals mean of pixels {0,1,2,11,12,13,22,23,24}=12; done once.
// - res_ready=0 whole frame -> pix_ready drops after 4 windows issued; 0 results lost.
//   Release res_ready -> frame completes, error=0.
// - pix_valid toggling 1/0 each cycle -> dp_valid mirrors accepts 1 cycle later; window_end only at
//   (row,col)=(2,2),(2,5),(2,8),(5,2)... ; 9 flags total.
// - Force dp_avg_ready pulse with outstanding=0 -> error=1, FIFO count unchanged; next start clears error.
// - Model never returns last average -> DRAIN flushes 64 cycles, error=1, done pulses, back to IDLE.
// - Assert reset mid-frame after 50 pixels -> outputs 0 immediately; new start runs a clean 9-result frame.

Source files
------------

// File: rtl/pool_window_scheduler.sv
// rtl/pool_window_scheduler.sv - frame sequencer and result buffer for the average-pooling datapath
//
// Ports:
//   clock, reset                  rising-edge clock, asynchronous active-high reset
//   start / busy / done / error   frame control and status (error is sticky until reset or next start)
//   pix_data/pix_valid/pix_ready  input pixel stream, row-major
//   dp_data/dp_valid/dp_window_end  pixel issue to the datapath, one cycle after accept
//   dp_avg/dp_avg_ready           averages returned by the datapath
//   res_data/res_index/res_valid/res_ready  pooled-result FIFO head
module pool_window_scheduler #(
    parameter int bitwidth    = 8,
    parameter int filterWidth = 3,
    parameter int imageWidth  = 11,
    parameter int imageHeight = 11,
    parameter int stride      = 3,
    parameter int fifoDepth   = 4,
    parameter int flushLimit  = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                error,
    input  logic [bitwidth-1:0] pix_data,
    input  logic                pix_valid,
    output logic                pix_ready,
    output logic [bitwidth-1:0] dp_data,
    output logic                dp_valid,
    output logic                dp_window_end,
    input  logic [bitwidth-1:0] dp_avg,
    input  logic                dp_avg_ready,
    output logic [bitwidth-1:0] res_data,
    output logic [15:0]         res_index,
    output logic                res_valid,
    input  logic                res_ready
);

    localparam int NWIN = ((imageWidth - filterWidth) / stride + 1) *
                          ((imageHeight - filterWidth) / stride + 1);
    localparam int CW   = $clog2(imageWidth);
    localparam int RW   = $clog2(imageHeight);
    localparam int AW   = $clog2(fifoDepth);
    localparam int FW   = $clog2(flushLimit + 1);
    localparam int EW   = bitwidth + 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   col;
    logic [RW-1:0]   row;
    logic [15:0]     out_cnt;     // windows issued whose average has not come back
    logic [15:0]     rx_cnt;      // averages matched this frame; doubles as the window index
    logic [FW-1:0]   flush_cnt;

    logic [EW-1:0]   mem [fifoDepth];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     fifo_cnt;

    logic [31:0]     col32;
    logic [31:0]     row32;
    logic            col_hit;
    logic            row_hit;
    logic            win_hit;
    logic            last_col;
    logic            last_row;
    logic            accept;
    logic            issue;
    logic            matched;
    logic            fifo_full;
    logic            pop;
    logic            push;
    logic [EW-1:0]   head;

    assign col32    = 32'(col);
    assign row32    = 32'(row);
    assign col_hit  = (col32 >= 32'(filterWidth - 1)) &&
                      (((col32 - 32'(filterWidth - 1)) % 32'(stride)) == 32'd0);
    assign row_hit  = (row32 >= 32'(filterWidth - 1)) &&
                      (((row32 - 32'(filterWidth - 1)) % 32'(stride)) == 32'd0);
    assign win_hit  = col_hit && row_hit;
    assign last_col = (col == CW'(imageWidth - 1));
    assign last_row = (row == RW'(imageHeight - 1));

    // Credit check counts both in-flight windows and buffered results, so every
    // average the datapath can still produce already has a FIFO slot reserved.
    assign pix_ready = (state == S_STREAM) &&
                       (({1'b0, out_cnt} + 17'(fifo_cnt)) < 17'(fifoDepth));
    assign accept    = pix_valid && pix_ready;
    assign issue     = accept && win_hit;

    // A pulse with nothing outstanding is unsolicited and never reaches the FIFO.
    assign matched   = dp_avg_ready && (out_cnt != 16'd0);
    assign fifo_full = (fifo_cnt == (AW + 1)'(fifoDepth));
    assign res_valid = (fifo_cnt != '0);
    assign pop       = res_valid && res_ready;
    assign push      = matched && (!fifo_full || pop);

    assign head      = mem[rd_ptr];
    assign res_data  = res_valid ? head[EW-1:16] : '0;
    assign res_index = res_valid ? head[15:0] : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            dp_data       <= '0;
            dp_valid      <= 1'b0;
            dp_window_end <= 1'b0;
            col           <= '0;
            row           <= '0;
            out_cnt       <= '0;
            rx_cnt        <= '0;
            flush_cnt     <= '0;
        end else begin
            done          <= 1'b0;
            dp_valid      <= 1'b0;
            dp_window_end <= 1'b0;

            if (matched) begin
                rx_cnt <= rx_cnt + 16'd1;
            end
            if (dp_avg_ready && !push) begin
                error <= 1'b1;
            end

            unique case ({issue, matched})
                2'b10:   out_cnt <= out_cnt + 16'd1;
                2'b01:   out_cnt <= out_cnt - 16'd1;
                default: out_cnt <= out_cnt;
            endcase

            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_STREAM;
                        busy      <= 1'b1;
                        error     <= 1'b0;
                        col       <= '0;
                        row       <= '0;
                        out_cnt   <= '0;
                        rx_cnt    <= '0;
                        flush_cnt <= '0;
                    end
                end
                S_STREAM: begin
                    if (accept) begin
                        dp_valid      <= 1'b1;
                        dp_data       <= pix_data;
                        dp_window_end <= win_hit;
                        if (last_col) begin
                            col <= '0;
                            row <= last_row ? '0 : row + RW'(1);
                        end else begin
                            col <= col + CW'(1);
                        end
                        if (last_col && last_row) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (rx_cnt == 16'(NWIN)) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (flush_cnt == FW'(flushLimit)) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        error <= 1'b1;
                    end else if (out_cnt != 16'd0) begin
                        // Zero pixels push the last windows through the datapath pipeline.
                        dp_valid  <= 1'b1;
                        dp_data   <= '0;
                        flush_cnt <= flush_cnt + FW'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Result FIFO: survives frame boundaries, only reset or pops empty it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (AW + 1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (AW + 1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= {dp_avg, rx_cnt};
        end
    end

endmodule

// File: tb/tb_pool_window_scheduler.sv
// tb/tb_pool_window_scheduler.sv - self-checking bench for pool_window_scheduler
module tb_pool_window_scheduler;

    localparam int IW   = 11;
    localparam int FWID = 3;
    localparam int STR  = 3;
    localparam int NPIX = 121;
    localparam int NWIN = 9;
    localparam int LAT  = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, error;
    logic [7:0]  pix_data = 8'd0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [7:0]  dp_data;
    logic        dp_valid, dp_window_end;
    logic [7:0]  dp_avg = 8'd0;
    logic        dp_avg_ready = 1'b0;
    logic [7:0]  res_data;
    logic [15:0] res_index;
    logic        res_valid;
    logic        res_ready = 1'b0;

    always #5 clock = ~clock;

    pool_window_scheduler dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .pix_data      (pix_data),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .dp_data       (dp_data),
        .dp_valid      (dp_valid),
        .dp_window_end (dp_window_end),
        .dp_avg        (dp_avg),
        .dp_avg_ready  (dp_avg_ready),
        .res_data      (res_data),
        .res_index     (res_index),
        .res_valid     (res_valid),
        .res_ready     (res_ready)
    );

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  stim [NPIX];
    logic [23:0] exp_q [$];
    logic [23:0] got_q [$];
    int          got_rd = 0;
    int          exp_idx = 0;
    bit          stalled = 0;

    int          we_cnt = 0, lag_bad = 0, dp_dat_bad = 0, dp_k = 0;
    int          acc_total = 0, flush_cnt = 0, flush_bad = 0, done_cnt = 0;
    int          we_pos [$];
    bit          prev_acc = 0;

    int          cyc = 0, mk = 0, wins = 0;
    logic [7:0]  pbuf [NPIX];
    int          pend_due [$];
    logic [7:0]  pend_avg [$];
    bit          prev_busy = 0;
    int          force_req = 0, force_ack = 0;
    bit          drop_last = 0;

    function automatic bit is_we(input int k);
        int r, c;
        r = k / IW;
        c = k % IW;
        return (r >= FWID - 1) && ((r - FWID + 1) % STR == 0) &&
               (c >= FWID - 1) && ((c - FWID + 1) % STR == 0);
    endfunction

    function automatic logic [7:0] ref_avg(input int k);
        int r, c, sum;
        r = k / IW;
        c = k % IW;
        sum = 0;
        for (int dr = 0; dr < FWID; dr++)
            for (int dc = 0; dc < FWID; dc++)
                sum += int'(stim[(r - FWID + 1 + dr) * IW + (c - FWID + 1 + dc)]);
        return 8'(sum / (FWID * FWID));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, 32'({busy, done, error, pix_ready, dp_valid, dp_window_end, res_valid}), 32'd0);
        chk({tag, "_dp_data"}, 32'(dp_data), 32'd0);
        chk({tag, "_res"}, 32'({res_index, res_data}), 32'd0);
    endtask

    task automatic start_frame();
        exp_idx = 0;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send_frame(input bit toggle, input bit hold, input int npix);
        int n;
        for (int k = 0; k < npix; k++) begin
            pix_valid = 1'b1;
            pix_data  = stim[k];
            n = 0;
            while (!pix_ready && n < 2000) begin
                step();
                n++;
                if (hold && n == 20 && !stalled) begin
                    stalled = 1;
                    chk("stall_windows_issued", 32'(we_cnt), 32'd4);
                    chk("stall_pix_ready", 32'(pix_ready), 32'd0);
                    chk("stall_res_valid", 32'(res_valid), 32'd1);
                    chk("stall_expected_pending", 32'(exp_q.size()), 32'd4);
                    res_ready = 1'b1;
                end
            end
            if (!pix_ready) begin
                chk("pix_ready_timeout", 32'd0, 32'd1);
                pix_valid = 1'b0;
                return;
            end
            if (is_we(k)) begin
                exp_q.push_back({16'(exp_idx), ref_avg(k)});
                exp_idx++;
            end
            step();
            if (toggle) begin
                pix_valid = 1'b0;
                step();
            end
        end
        pix_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 1000) begin
            step();
            n++;
        end
        chk({tag, "_done_seen"}, 32'(done), 32'd1);
        repeat (8) step();
    endtask

    task automatic check_results(input string tag, input int n);
        logic [23:0] e, g;
        chk({tag, "_count"}, 32'(got_q.size() - got_rd), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (got_rd >= got_q.size() || exp_q.size() == 0) break;
            e = exp_q.pop_front();
            g = got_q[got_rd];
            got_rd++;
            chk({tag, "_index"}, 32'(g[23:8]), 32'(e[23:8]));
            chk({tag, "_avg"}, 32'(g[7:0]), 32'(e[7:0]));
        end
        exp_q.delete();
    endtask

    task automatic mon_clear();
        we_cnt = 0; lag_bad = 0; dp_dat_bad = 0; dp_k = 0;
        acc_total = 0; flush_cnt = 0; flush_bad = 0; done_cnt = 0;
        we_pos.delete();
        prev_acc = 0;
    endtask

    // Monitor: samples on the falling edge, appends popped results to got_q.
    initial forever begin
        @(negedge clock);
        if (reset) begin
            mon_clear();
        end else begin
            if (start && !busy && !done) mon_clear();
            if (acc_total < NPIX || prev_acc)
                if (dp_valid !== prev_acc) lag_bad++;
            if (dp_valid) begin
                if (dp_k < NPIX) begin
                    if (dp_data !== stim[dp_k]) dp_dat_bad++;
                    if (dp_window_end) begin
                        we_cnt++;
                        we_pos.push_back(dp_k);
                    end
                    dp_k++;
                end else begin
                    flush_cnt++;
                    if (dp_data !== 8'd0 || dp_window_end) flush_bad++;
                end
            end
            prev_acc = pix_valid && pix_ready;
            if (prev_acc) acc_total++;
            if (res_valid && res_ready) got_q.push_back({res_index, res_data});
            if (done) done_cnt++;
        end
    end

    // Datapath model: averages each completed window from the pixels it was fed,
    // returns it LAT cycles later as a one-cycle dp_avg_ready pulse.
    initial forever begin
        int r, c, sum;
        @(posedge clock);
        #1;
        dp_avg_ready = 1'b0;
        if (reset) begin
            pend_due.delete();
            pend_avg.delete();
            mk = 0;
            wins = 0;
            prev_busy = 0;
        end else begin
            cyc++;
            if (busy && !prev_busy) begin
                mk = 0;
                wins = 0;
            end
            prev_busy = busy;
            if (dp_valid && mk < NPIX) begin
                pbuf[mk] = dp_data;
                if (dp_window_end) begin
                    r = mk / IW;
                    c = mk % IW;
                    sum = 0;
                    for (int dr = 0; dr < FWID; dr++)
                        for (int dc = 0; dc < FWID; dc++)
                            sum += int'(pbuf[(r - FWID + 1 + dr) * IW + (c - FWID + 1 + dc)]);
                    wins++;
                    if (!(drop_last && wins == NWIN)) begin
                        pend_due.push_back(cyc + LAT);
                        pend_avg.push_back(8'(sum / (FWID * FWID)));
                    end
                end
                mk++;
            end
            if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                dp_avg = pend_avg.pop_front();
                pend_due.delete(0);
                dp_avg_ready = 1'b1;
            end else if (force_req != force_ack) begin
                force_ack = force_req;
                dp_avg = 8'hA5;
                dp_avg_ready = 1'b1;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog_timeout");
        $fatal(1);
    end

    initial begin
        int saved;
        int exp_pos [9];
        exp_pos = '{24, 27, 30, 57, 60, 63, 90, 93, 96};

        repeat (3) step();
        chk_zero("reset");
        reset = 1'b0;
        step();

        // Frame 1: ramp 0..120, consumer always ready.
        for (int k = 0; k < NPIX; k++) stim[k] = 8'(k);
        res_ready = 1'b1;
        start_frame();
        send_frame(0, 0, NPIX);
        wait_done("t1");
        chk("t1_first_avg", (got_q.size() > got_rd) ? 32'(got_q[got_rd][7:0]) : 32'hFFFF, 32'd12);
        check_results("t1", NWIN);
        chk("t1_done_once", 32'(done_cnt), 32'd1);
        chk("t1_error", 32'(error), 32'd0);
        chk("t1_window_flags", 32'(we_cnt), 32'd9);
        chk("t1_dp_lag", 32'(lag_bad), 32'd0);
        chk("t1_dp_data", 32'(dp_dat_bad), 32'd0);
        chk("t1_busy_idle", 32'(busy), 32'd0);

        // Frame 2: consumer stalled, credits must throttle input.
        for (int k = 0; k < NPIX; k++) stim[k] = 8'($urandom_range(0, 255));
        res_ready = 1'b0;
        stalled = 0;
        start_frame();
        send_frame(0, 1, NPIX);
        chk("t2_stalled", 32'(stalled), 32'd1);
        wait_done("t2");
        check_results("t2", NWIN);
        chk("t2_error", 32'(error), 32'd0);
        chk("t2_done_once", 32'(done_cnt), 32'd1);

        // Frame 3: pix_valid toggles every cycle.
        for (int k = 0; k < NPIX; k++) stim[k] = 8'((NPIX - 1 - k) * 2);
        res_ready = 1'b1;
        start_frame();
        send_frame(1, 0, NPIX);
        wait_done("t3");
        check_results("t3", NWIN);
        chk("t3_window_flags", 32'(we_cnt), 32'd9);
        for (int i = 0; i < 9; i++)
            chk("t3_window_pos", (we_pos.size() > i) ? 32'(we_pos[i]) : 32'hFFFF, 32'(exp_pos[i]));
        chk("t3_dp_lag", 32'(lag_bad), 32'd0);
        chk("t3_dp_data", 32'(dp_dat_bad), 32'd0);

        // Unsolicited average while idle.
        saved = got_q.size();
        force_req++;
        repeat (4) step();
        chk("t4_error_set", 32'(error), 32'd1);
        chk("t4_res_valid", 32'(res_valid), 32'd0);
        chk("t4_no_result", 32'(got_q.size()), 32'(saved));

        // Frame 5: last average never returns, flush times out.
        for (int k = 0; k < NPIX; k++) stim[k] = 8'($urandom_range(0, 255));
        drop_last = 1;
        start_frame();
        chk("t4_start_clears_error", 32'(error), 32'd0);
        send_frame(0, 0, NPIX);
        wait_done("t5");
        chk("t5_flush_cycles", 32'(flush_cnt), 32'd64);
        chk("t5_flush_content", 32'(flush_bad), 32'd0);
        chk("t5_error", 32'(error), 32'd1);
        chk("t5_done_once", 32'(done_cnt), 32'd1);
        chk("t5_busy_idle", 32'(busy), 32'd0);
        check_results("t5", NWIN - 1);

        // Frame 6: reset mid-frame, then a clean frame.
        drop_last = 0;
        for (int k = 0; k < NPIX; k++) stim[k] = 8'(k);
        start_frame();
        send_frame(0, 0, 50);
        reset = 1'b1;
        #1;
        chk_zero("t6_reset");
        step();
        step();
        exp_q.delete();
        got_rd = got_q.size();
        reset = 1'b0;
        step();
        start_frame();
        send_frame(0, 0, NPIX);
        wait_done("t6");
        check_results("t6", NWIN);
        chk("t6_error", 32'(error), 32'd0);
        chk("t6_done_once", 32'(done_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
